// File: rtl/blur_bram_read_arbiter.sv
// Round-robin arbiter sharing the blurred-image BRAM read port between the UART
// sender (requester 0) and the DoG reader (requester 1), with burst locking and tagged read returns.
module blur_bram_read_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,

    input  logic                  req0_in,
    input  logic [ADDR_WIDTH-1:0] addr0_in,
    input  logic                  lock0_in,
    output logic                  gnt0_out,
    output logic                  valid0_out,

    input  logic                  req1_in,
    input  logic [ADDR_WIDTH-1:0] addr1_in,
    input  logic                  lock1_in,
    output logic                  gnt1_out,
    output logic                  valid1_out,

    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic                  bram_en_out,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Handshake: reqN/addrN are held by the requester until gntN is seen high in the
    // same cycle; gntN means the read was issued, and validN follows exactly
    // READ_LATENCY cycles later with the word on data_out. Dropping reqN before a grant abandons the read.

    logic last_owner;
    logic locked;
    logic lock_owner;
    logic owner_lock;
    logic gnt_id;

    logic [READ_LATENCY-1:0] tag_v;
    logic [READ_LATENCY-1:0] tag_id;

    always_comb begin
        gnt0_out = 1'b0;
        gnt1_out = 1'b0;
        if (!rst_in) begin
            if (locked) begin
                // The non-owner stays stalled even while the owner is idle.
                if (lock_owner) gnt1_out = req1_in;
                else            gnt0_out = req0_in;
            end else if (req0_in && !req1_in) begin
                gnt0_out = 1'b1;
            end else if (req1_in && !req0_in) begin
                gnt1_out = 1'b1;
            end else if (req0_in && req1_in) begin
                if (last_owner) gnt0_out = 1'b1;
                else            gnt1_out = 1'b1;
            end
        end
    end

    assign gnt_id        = gnt1_out;
    assign bram_en_out   = gnt0_out | gnt1_out;
    assign bram_addr_out = gnt1_out ? addr1_in : addr0_in;
    assign owner_lock    = lock_owner ? lock1_in : lock0_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_owner <= 1'b1;
            locked     <= 1'b0;
            lock_owner <= 1'b0;
        end else begin
            if (locked && !owner_lock) begin
                locked <= 1'b0;
            end
            // While locked only the owner is granted, so a grant with its lock high keeps the lock.
            if (bram_en_out) begin
                last_owner <= gnt_id;
                if (gnt_id ? lock1_in : lock0_in) begin
                    locked     <= 1'b1;
                    lock_owner <= gnt_id;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_v  <= '0;
            tag_id <= '0;
        end else begin
            tag_v[0]  <= bram_en_out;
            tag_id[0] <= gnt_id;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign valid0_out = tag_v[READ_LATENCY-1] & ~tag_id[READ_LATENCY-1];
    assign valid1_out = tag_v[READ_LATENCY-1] &  tag_id[READ_LATENCY-1];
    assign data_out   = bram_data_in;

endmodule

// File: doc/blur_bram_read_arbiter.md
Name: blur_bram_read_arbiter

Overview:
- Shares the single read port (port B) of the blurred-image BRAM between two requesters.
- Requester 0 is the UART image sender. Requester 1 is the next SIFT stage, a difference-of-Gaussians reader.
- Arbitration is round-robin, with an optional lock so that one requester can stream a burst uninterrupted.
- Returned read data is tagged so that only the requester that issued a read sees the matching valid pulse, READ_LATENCY cycles later.

Parameters:
- ADDR_WIDTH, 12, BRAM address width (64*64 image = 4096 words).
- DATA_WIDTH, 8, pixel bit depth.
- READ_LATENCY, 2, BRAM cycles from address/enable to valid dout (port B with output register enabled). Legal range 1..4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- req0_in  input  1  requester 0 wants a read this cycle.
- addr0_in  input  ADDR_WIDTH  requester 0 read address.
- lock0_in  input  1  requester 0 asks to keep ownership after this grant.
- gnt0_out  output  1  requester 0 read issued this cycle (combinational).
- valid0_out  output  1  data_out holds requester 0's data.
- req1_in  input  1  requester 1 wants a read.
- addr1_in  input  ADDR_WIDTH  requester 1 read address.
- lock1_in  input  1  requester 1 lock request.
- gnt1_out  output  1  requester 1 read issued this cycle.
- valid1_out  output  1  data_out holds requester 1's data.
- bram_addr_out  output  ADDR_WIDTH  to BRAM addrb.
- bram_en_out  output  1  to BRAM enb.
- bram_data_in  input  DATA_WIDTH  from BRAM doutb.
- data_out  output  DATA_WIDTH  shared read data to both requesters.

Behaviour:
- Single clock clk_in; rst_in is synchronous and active-high. All state updates on posedge clk_in.
- State registers:
  - last_owner (1 bit), reset to 1 so that requester 0 wins first contention.
  - locked (1 bit), reset to 0.
  - lock_owner (1 bit), reset to 0.
  - tag pipeline: READ_LATENCY stages of {v, owner}, all cleared on reset.
- Grant logic is combinational, in priority order:
  1. rst_in = 1: no grant.
  2. locked = 1: only lock_owner may be granted, and only if its req is high. The other requester is stalled even when the owner is idle.
  3. Exactly one req high: grant that requester.
  4. Both req high: grant !last_owner.
- Outputs:
  - gntN_out = granted requester is N.
  - bram_en_out = gnt0_out | gnt1_out.
  - bram_addr_out = address of the granted requester; addr0_in when idle.
- Updates on a grant to N:
  - last_owner <= N.
  - If lockN_in = 1: locked <= 1 and lock_owner <= N.
- Lock release: while locked, any cycle with lock_owner's lock input low sets locked <= 0. Release happens whether or not a grant occurs that cycle, and a grant that same cycle is still issued.
- Tag pipeline:
  - Stage 0 <= {bram_en_out, granted id}; each later stage shifts by one per cycle.
  - validN_out = last stage v and owner == N. This is registered and asserts exactly READ_LATENCY cycles after gntN_out.
  - data_out = bram_data_in, passed through combinationally. Address/data alignment is guaranteed by READ_LATENCY matching the BRAM configuration.
- Throughput: one read per cycle sustained. Back-to-back grants to alternating requesters are legal. Valids return in issue order.
- Reset values: gnt0_out = 0, gnt1_out = 0, bram_en_out = 0, valid0_out = 0, valid1_out = 0, bram_addr_out = addr0_in.
- Reset mid-operation: in-flight reads are dropped. No valid pulse may appear after rst_in, even if the BRAM still returns data. Any lock is cleared.
- Requesters must hold reqN_in and addrN_in until gntN_out. A req deasserted without a grant is a legal abandon.
- A lock asserted by a requester that is not granted that cycle has no effect.

Test Plan:
- Reset pulse with both reqs high: gnt0 = gnt1 = 0 during reset. On the first cycle after reset, gnt0_out = 1 with addr 0x010; valid0_out pulses 2 cycles later carrying BRAM word 0x010.
- req0 only, addresses 0..4095 streamed: 4096 grants, 4096 valid0 pulses, zero valid1 pulses. data_out matches a BRAM model preloaded with addr[7:0].
- Both reqs held high for 8 cycles, no locks: grants alternate 0,1,0,1,… and valid0/valid1 alternate with the same pattern delayed 2 cycles.
- req1 with lock1 high for 16 reads while req0 stays high: 16 consecutive gnt1 and zero gnt0. The cycle lock1 drops: gnt1 still issued. Next cycle: gnt0.
- Lock owner 1 idles (req1 = 0, lock1 = 1) for 5 cycles with req0 high: bram_en_out = 0 for those 5 cycles, then gnt0 on the first cycle after lock1 falls.
- rst_in asserted for 1 cycle, 1 cycle after gnt0: no valid0 pulse follows, locked cleared, and the next contention is won by requester 0.
